// File: rtl/note_detector_if.sv
// Bundle of the per-frame correlation input and the published note outputs.
// The master side drives the correlation vector; the slave side (detector)
// returns the published note, its valid pulse, peak magnitude and busy flag.
interface note_detector_if;
  logic [597:0] Y_in;
  logic [3:0]   note_out;
  logic         note_valid;
  logic [45:0]  peak_out;
  logic         busy;

  modport master (
    output Y_in,
    input  note_out,
    input  note_valid,
    input  peak_out,
    input  busy
  );

  modport slave (
    input  Y_in,
    output note_out,
    output note_valid,
    output peak_out,
    output busy
  );
endinterface

// File: rtl/note_detector.sv
// Note detector: snapshots a 13-note correlation frame whenever it changes,
// scans one note per cycle for the largest magnitude (ties keep the lower
// index), applies a presence threshold, and debounces the decision before
// publishing a new note index with a single-cycle valid pulse.
module note_detector #(
  parameter logic [45:0] THRESHOLD    = 46'd65536,
  parameter int          STABLE_COUNT = 3
) (
  input  logic            clk,
  input  logic            resetn,
  note_detector_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

  localparam logic [3:0]  NO_NOTE  = 4'hF;
  localparam logic [3:0]  LAST_IDX = 4'd12;
  localparam logic [45:0] MOST_NEG = {1'b1, 45'd0};
  localparam logic [45:0] MAX_MAG  = {1'b0, {45{1'b1}}};

  state_t        state_reg;
  logic [597:0]  snapshot_reg;
  logic [3:0]    index_reg;
  logic [45:0]   max_reg;
  logic [3:0]    best_reg;
  logic [3:0]    last_cand_reg;
  logic [3:0]    count_reg;
  logic [3:0]    note_out_reg;
  logic          note_valid_reg;
  logic [45:0]   peak_reg;
  logic          busy_reg;

  logic [45:0]   note_val [13];
  logic [45:0]   cur_note;
  logic [45:0]   abs_val;
  logic [3:0]    candidate;
  logic [3:0]    count_next;

  // Unpack the captured frame into one word per note.
  generate
    for (genvar gi = 0; gi < 13; gi++) begin : g_unpack
      assign note_val[gi] = snapshot_reg[46*gi +: 46];
    end
  endgenerate

  // Select the note under scan and take its saturated magnitude.
  always_comb begin
    cur_note = '0;
    for (int k = 0; k < 13; k++) begin
      if (index_reg == 4'(k)) cur_note = note_val[k];
    end
    if (!cur_note[45])
      abs_val = cur_note;
    else if (cur_note == MOST_NEG)
      abs_val = MAX_MAG;
    else
      abs_val = ~cur_note + 46'd1;
  end

  // Threshold the frame winner and compute the debounce counter update.
  always_comb begin
    candidate = (max_reg > THRESHOLD) ? best_reg : NO_NOTE;
    if (candidate == last_cand_reg)
      count_next = (count_reg == 4'd15) ? 4'd15 : count_reg + 4'd1;
    else
      count_next = 4'd1;
  end

  // Frame FSM: capture on change, scan 13 notes, decide, back to idle.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_reg      <= IDLE;
      snapshot_reg   <= '0;
      index_reg      <= '0;
      max_reg        <= '0;
      best_reg       <= NO_NOTE;
      last_cand_reg  <= NO_NOTE;
      count_reg      <= '0;
      note_out_reg   <= NO_NOTE;
      note_valid_reg <= 1'b0;
      peak_reg       <= '0;
      busy_reg       <= 1'b0;
    end else begin
      note_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Only the value present when idle is seen; anything that
          // changed and changed again while busy is simply skipped.
          if (bus.Y_in != snapshot_reg) begin
            snapshot_reg <= bus.Y_in;
            index_reg    <= '0;
            max_reg      <= '0;
            best_reg     <= NO_NOTE;
            busy_reg     <= 1'b1;
            state_reg    <= SCAN;
          end
        end
        SCAN: begin
          // Strict compare keeps the earliest index on equal magnitudes.
          if (abs_val > max_reg) begin
            max_reg  <= abs_val;
            best_reg <= index_reg;
          end
          if (index_reg == LAST_IDX)
            state_reg <= DECIDE;
          else
            index_reg <= index_reg + 4'd1;
        end
        DECIDE: begin
          peak_reg      <= max_reg;
          last_cand_reg <= candidate;
          count_reg     <= count_next;
          if ((count_next == 4'(STABLE_COUNT)) && (candidate != note_out_reg)) begin
            note_out_reg   <= candidate;
            note_valid_reg <= 1'b1;
          end
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.note_out   = note_out_reg;
  assign bus.note_valid = note_valid_reg;
  assign bus.peak_out   = peak_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector: directed frame table with hand-derived results,
// multi-cycle corner sequences, then random frames against a frame-level model.
module tb_note_detector;
  localparam int          STABLE = 3;
  localparam logic [45:0] THR    = 46'd65536;
  localparam longint      MAXMAG = (64'sd1 <<< 45) - 1;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  note_detector_if bus ();

  note_detector #(.THRESHOLD(THR), .STABLE_COUNT(STABLE)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [597:0] y;
    longint       peak;
    int           nout;
    bit           pulse;
  } vec_t;

  // Debounce model state: last decision, its repeat count, published note.
  int m_last = 15;
  int m_cnt  = 0;
  int m_pub  = 15;

  function automatic void check(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [597:0] mk(int ka, longint va, int kb, longint vb, int kc, longint vc);
    logic [597:0] y;
    y = '0;
    if (ka >= 0) y[46*ka +: 46] = va[45:0];
    if (kb >= 0) y[46*kb +: 46] = vb[45:0];
    if (kc >= 0) y[46*kc +: 46] = vc[45:0];
    return y;
  endfunction

  // Frame winner: largest magnitude, first index wins ties, threshold applied.
  function automatic void ref_eval(input logic [597:0] y, output longint peak, output int cand);
    int idx;
    peak = 0;
    idx = 15;
    for (int k = 0; k < 13; k++) begin
      logic [45:0] raw;
      longint v;
      longint a;
      raw = y[46*k +: 46];
      v = raw[45] ? longint'(raw) - (64'sd1 <<< 46) : longint'(raw);
      a = (v < 0) ? -v : v;
      if (a > MAXMAG) a = MAXMAG;
      if (a > peak) begin
        peak = a;
        idx = k;
      end
    end
    cand = (peak > longint'(THR)) ? idx : 15;
  endfunction

  task automatic model_step(input logic [597:0] y, output longint peak, output int nout, output bit pulse);
    int cand;
    ref_eval(y, peak, cand);
    if (cand == m_last) begin
      if (m_cnt < 15) m_cnt++;
    end else begin
      m_last = cand;
      m_cnt = 1;
    end
    pulse = (m_cnt == STABLE) && (cand != m_pub);
    if (pulse) m_pub = cand;
    nout = m_pub;
  endtask

  // Present one frame, wait for it to finish and check every output.
  task automatic frame_check(input string tag, input logic [597:0] y, input bit use_tab,
                             input longint tpeak, input int tnout, input bit tpulse);
    longint mpeak;
    int mnout;
    bit mpulse;
    int busy_cycles;
    model_step(y, mpeak, mnout, mpulse);
    @(negedge clk);
    bus.Y_in = y;
    @(posedge clk); #1;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      busy_cycles++;
      @(posedge clk); #1;
    end
    check({tag, " busy_len"}, busy_cycles, 14);
    check({tag, " peak"}, longint'(bus.peak_out), use_tab ? tpeak : mpeak);
    check({tag, " note_out"}, longint'(bus.note_out), use_tab ? tnout : mnout);
    check({tag, " valid"}, longint'(bus.note_valid), use_tab ? tpulse : mpulse);
    @(posedge clk); #1;
    check({tag, " valid_after"}, longint'(bus.note_valid), 0);
    check({tag, " idle_after"}, longint'(bus.busy), 0);
  endtask

  vec_t tab [14];

  initial begin
    logic [597:0] y;
    logic [597:0] prev;
    longint pk;
    int no;
    bit pl;
    int frames;
    int highs;
    bit prev_busy;
    longint first_peak;
    longint last_peak;

    tab[0]  = '{mk(4, 200000, -1, 0, -1, 0),         200000, 15, 1'b0};
    tab[1]  = '{mk(4, 200000, 0, 5, -1, 0),          200000, 15, 1'b0};
    tab[2]  = '{mk(4, 200000, 1, 7, -1, 0),          200000, 4,  1'b1};
    tab[3]  = '{mk(2, -300000, 9, 250000, -1, 0),    300000, 4,  1'b0};
    tab[4]  = '{mk(2, -300000, 9, 250000, 0, 1),     300000, 4,  1'b0};
    tab[5]  = '{mk(2, -300000, 9, 250000, 0, 2),     300000, 2,  1'b1};
    tab[6]  = '{mk(3, 100000, 7, 100000, -1, 0),     100000, 2,  1'b0};
    tab[7]  = '{mk(3, 100000, 7, 100000, 12, 3),     100000, 2,  1'b0};
    tab[8]  = '{mk(3, 100000, 7, 100000, 12, 4),     100000, 3,  1'b1};
    tab[9]  = '{mk(5, 65536, -1, 0, -1, 0),          65536,  3,  1'b0};
    tab[10] = '{mk(6, -65536, 0, -100, -1, 0),       65536,  3,  1'b0};
    tab[11] = '{mk(11, 1000, -1, 0, -1, 0),          1000,   15, 1'b1};
    tab[12] = '{mk(4, 65537, -1, 0, -1, 0),          65537,  15, 1'b0};
    tab[13] = '{mk(0, -(64'sd1 <<< 45), -1, 0, -1, 0), MAXMAG, 15, 1'b0};

    // Reset state and a zero input that must not start a frame.
    bus.Y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst note_out", longint'(bus.note_out), 15);
    check("rst valid", longint'(bus.note_valid), 0);
    check("rst peak", longint'(bus.peak_out), 0);
    check("rst busy", longint'(bus.busy), 0);
    @(negedge clk);
    resetn = 1'b0;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.busy) highs++;
    end
    check("zero_no_frame", highs, 0);

    // Directed frame table.
    for (int i = 0; i < 14; i++) begin
      frame_check($sformatf("tab%0d", i), tab[i].y, 1'b1, tab[i].peak, tab[i].nout, tab[i].pulse);
    end
    prev = tab[13].y;

    // Input changes three times during a scan: only first and last are processed.
    frames = 0;
    first_peak = -1;
    last_peak = -1;
    @(negedge clk);
    bus.Y_in = mk(8, 150000, -1, 0, -1, 0);
    @(posedge clk); #1;
    prev_busy = bus.busy;
    @(negedge clk); bus.Y_in = mk(9, 170000, -1, 0, -1, 0);
    @(negedge clk); bus.Y_in = mk(1, 180000, -1, 0, -1, 0);
    @(negedge clk); bus.Y_in = mk(10, -220000, -1, 0, -1, 0);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (prev_busy && !bus.busy) begin
        frames++;
        if (frames == 1) first_peak = longint'(bus.peak_out);
        last_peak = longint'(bus.peak_out);
      end
      prev_busy = bus.busy;
    end
    check("drop frames", frames, 2);
    model_step(mk(8, 150000, -1, 0, -1, 0), pk, no, pl);
    check("drop first_peak", first_peak, pk);
    model_step(mk(10, -220000, -1, 0, -1, 0), pk, no, pl);
    check("drop last_peak", last_peak, pk);
    check("drop note_out", longint'(bus.note_out), no);
    prev = mk(10, -220000, -1, 0, -1, 0);

    // Randomized frames against the model.
    for (int n = 0; n < 40; n++) begin
      int w;
      longint val;
      y = '0;
      w = $urandom_range(0, 3);
      for (int k = 0; k < 13; k++) begin
        val = longint'($urandom_range(0, 90000));
        if ($urandom_range(0, 1) == 1) val = -val;
        y[46*k +: 46] = val[45:0];
      end
      if ($urandom_range(0, 7) != 0) begin
        val = longint'($urandom_range(65000, 400000));
        if ($urandom_range(0, 1) == 1) val = -val;
        y[46*w +: 46] = val[45:0];
        if ($urandom_range(0, 4) == 0) begin
          val = -val;
          y[46*(w+5) +: 46] = val[45:0];
        end
      end
      if (y == prev) y[0] = ~y[0];
      frame_check($sformatf("rnd%0d", n), y, 1'b0, 0, 0, 1'b0);
      prev = y;
    end

    // Reset during the sixth scan cycle aborts the frame.
    y = mk(1, 500000, -1, 0, -1, 0);
    if (y == prev) y = mk(1, 500001, -1, 0, -1, 0);
    @(negedge clk);
    bus.Y_in = y;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("abort note_out", longint'(bus.note_out), 15);
    check("abort valid", longint'(bus.note_valid), 0);
    check("abort peak", longint'(bus.peak_out), 0);
    check("abort busy", longint'(bus.busy), 0);
    @(negedge clk);
    resetn = 1'b0;
    m_last = 15;
    m_cnt = 0;
    m_pub = 15;
    @(posedge clk); #1;
    check("restart busy", longint'(bus.busy), 1);
    model_step(y, pk, no, pl);
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      @(posedge clk); #1;
    end
    check("restart done", longint'(bus.busy), 0);
    check("restart peak", longint'(bus.peak_out), pk);
    check("restart note_out", longint'(bus.note_out), no);
    check("restart valid", longint'(bus.note_valid), pl);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/note_detector.md
NOTE_DETECTOR -- requirements
Module: note_detector

Interface
REQ-001 Parameter THRESHOLD, default 46'd65536, minimum peak magnitude required to declare a note present.
REQ-002 Parameter STABLE_COUNT, default 3, number of consecutive identical decisions required before the published note changes (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-high (asserted when 1).
REQ-005 Y_in  input  598  13 signed 46-bit note correlation results, packed: note k occupies bits [46k+45:46k], k=0 (A4) .. 12 (A5).
REQ-006 note_out  output  4  published note index 0..12; 4'hF = silence/no note.
REQ-007 note_valid  output  1  one-cycle pulse when note_out changes.
REQ-008 peak_out  output  46  unsigned absolute magnitude of the winning note from the latest decision.
REQ-009 busy  output  1  high while a frame is being scanned or decided.

Function
REQ-010 FSM states SHALL be IDLE, SCAN, DECIDE; after reset the state is IDLE.
REQ-011 In IDLE, if Y_in != snapshot register, the block SHALL copy Y_in into snapshot, clear index to 0, clear running max to 0, set best index to 4'hF, and enter SCAN at the same edge; if Y_in equals snapshot, it stays in IDLE.
REQ-012 In SCAN, one note per cycle: index k = 0..12 in order; abs_k = |snapshot note k|; a negative value SHALL be two's-complement negated; -2^45 SHALL saturate to 2^45-1.
REQ-013 Running max SHALL update only when abs_k > max (strict), so on a tie the lower index wins.
REQ-014 After index 12 is evaluated, the FSM SHALL enter DECIDE; SCAN lasts exactly 13 cycles.
REQ-015 In DECIDE (one cycle): candidate = best index if max > THRESHOLD, else 4'hF; peak_out <= max regardless of threshold.
REQ-016 Debounce: if candidate == last candidate, stable counter increments, saturating at 15; otherwise last candidate <= candidate and counter <= 1.
REQ-017 When the updated counter == STABLE_COUNT and candidate != note_out, note_out <= candidate and note_valid SHALL pulse high for exactly one cycle; otherwise note_valid stays 0.
REQ-018 After DECIDE the FSM SHALL return to IDLE; latency from the capture edge to the note_valid edge is 14 clocks; minimum frame period is 15 clocks.
REQ-019 busy SHALL be 1 in SCAN and DECIDE, 0 in IDLE.
REQ-020 Changes on Y_in while busy SHALL be ignored; on return to IDLE the current Y_in is compared with snapshot, so only the latest pending value is processed and intermediate values are dropped.
REQ-021 Internal max/abs arithmetic SHALL be 46-bit unsigned; no result is truncated.

Reset
REQ-022 While resetn=1: state IDLE, snapshot 0, index 0, max 0, last candidate 4'hF, counter 0, note_out 4'hF, note_valid 0, peak_out 0, busy 0.
REQ-023 Reset asserted mid-SCAN or mid-DECIDE SHALL abort the frame with no output update; after release, a nonzero Y_in is detected as a new frame (snapshot is 0).
REQ-024 Y_in = 0 after reset SHALL NOT start a frame.

Verification
REQ-025 Reset, then Y_in with note 4 = +200000, all others 0, held; STABLE_COUNT=3 -> exactly one scan (busy high for 14 cycles), note_out stays 4'hF, peak_out=200000; present three distinct frames all with note 4 dominant -> note_valid pulse on the third DECIDE, note_out=4.
REQ-026 Frame with note 2 = -300000 and note 9 = +250000 -> candidate 2, peak_out=300000 (sign ignored).
REQ-027 Frame with notes 3 and 7 both = +100000 -> candidate 3 (tie goes to lower index).
REQ-028 With note_out=4 published, three frames where all notes <= 65536 -> note_out=4'hF with one note_valid pulse; exactly 65536 counts as silence.
REQ-029 Change Y_in three times during one scan -> only the frame captured at start and the final Y_in value are processed (two frames total).
REQ-030 Note 0 = -2^45 -> peak_out = 2^45-1; assert resetn during cycle 6 of SCAN -> all outputs at reset values the next cycle, no note_valid.
